mc_main_control_fsm: RTL and testbench
======================================

// Module: mc_main_control_fsm
// PURPOSE
//  Main control FSM of the multicycle MIPS core. Steps each instruction through fetch/decode/execute/mem/writeback.
//  Drives every datapath enable and mux select, plus the 2-bit ALUOp consumed by the ALU decoder.
//  Waits on a memory-ready handshake during instruction fetch, load and store.
// PARAMETERS
//  STATE_W   4         state register width (13 states; must stay >=4)
//  OP_RTYPE  6'h00     R-type opcode
//  OP_LW     6'h23     lw opcode
//  OP_SW     6'h2B     sw opcode
//  OP_BEQ    6'h04     beq opcode
//  OP_ADDI   6'h08     addi opcode
//  OP_J      6'h02     j opcode (decoded only when MC_JUMP_EN is defined)
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous, active-high reset
//  opcode     in   6  instr[31:26] from the instruction register
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory done this cycle (rd data valid / write accepted)
//  IorD       out  1  memory address select: 0=PC, 1=ALUOut
//  MemWrite   out  1  memory write strobe
//  IRWrite    out  1  instruction register load
//  RegDst     out  1  write-register select: 0=rt, 1=rd
//  MemtoReg   out  1  write-data select: 0=ALUOut, 1=Data
//  RegWrite   out  1  register file write
//  ALUSrcA    out  1  ALU A select: 0=PC, 1=A
//  ALUSrcB    out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  ALUOp      out  2  00=add, 01=sub, 10=use funct
//  PCSrc      out  2  00=ALUResult, 01=ALUOut, 10=jump target
//  PCEn       out  1  PC load = PCWrite | (Branch & zero)
//  illegal_op out  1  one-cycle pulse: unsupported opcode seen in DECODE
// BEHAVIOUR
//  - Moore outputs decoded from the registered state. Exceptions: PCEn uses live zero;
//    FETCH IRWrite/PCWrite are gated by mem_ready.
//  - Unlisted outputs are 0 in every state.
//  - rst=1 at a clock edge -> state=RESET, regardless of current state (including mid-load/store).
//    In RESET all outputs are 0; the next edge goes to FETCH.
//  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready.
//    Stay in FETCH while !mem_ready; else -> DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
//    lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEX, j->JUMP.
//    Any other opcode -> FETCH with illegal_op=1 for that DECODE cycle.
//  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw->MEMREAD, sw->MEMWRITE.
//  - MEMREAD: IorD=1; hold while !mem_ready; else -> MEMWB.
//  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
//  - MEMWRITE: IorD=1, MemWrite=1 held until mem_ready; then -> FETCH.
//  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
//    ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
//    PCEn=zero in this state.
//  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
//    ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
//  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
//  - Unused state encodings -> FETCH on the next edge, outputs 0.
//  - Cycles per instruction with mem_ready always 1:
//    lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
//  - opcode is sampled only in DECODE and MEMADR; the IR is stable then because IRWrite=0.
// CONFIGURATION
//  MC_JUMP_EN defined:
//    JUMP state exists; opcode OP_J in DECODE -> JUMP.
//  MC_JUMP_EN undefined:
//    No JUMP state; PCSrc never 10; OP_J is treated as illegal (illegal_op pulse, -> FETCH).
// TESTING
//  1. rst=1 for 2 cycles, release:
//     -> all outputs 0 in the RESET cycle; FETCH next with ALUSrcB=01, IRWrite=PCWrite=PCEn=1 (mem_ready=1).
//  2. lw (0x23), mem_ready=1:
//     -> 5-cycle sequence FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 5.
//  3. sw (0x2B), mem_ready low for 3 cycles in MEMWRITE:
//     -> MemWrite=1 for 4 cycles, then FETCH.
//  4. beq (0x04) with zero=1, then zero=0:
//     -> BRANCH has ALUOp=01, PCSrc=01; PCEn=1 then 0.
//  5. R-type (0x00), then addi (0x08):
//     -> EXECUTE ALUOp=10, ALUWB RegDst=1; ADDIEX ALUSrcB=10, ADDIWB RegDst=0; both 4 cycles.
//  6. opcode 0x3F, and j (0x02) in both macro builds; rst=1 during MEMREAD:
//     -> 0x3F: illegal_op 1-cycle pulse.
//     -> j: JUMP PCSrc=10 with MC_JUMP_EN, illegal pulse without it.
//     -> rst during MEMREAD: RESET next cycle.

Source files
------------

// File: rtl/mc_main_control_fsm.sv
// mc_main_control_fsm: multicycle MIPS main control FSM (fetch/decode/execute/mem/writeback).
// Define MC_JUMP_EN to add the JUMP state for the j instruction; otherwise j decodes as illegal.
module mc_main_control_fsm #(
   parameter int         STATE_W  = 4,
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_ADDI  = 6'h08,
   parameter logic [5:0] OP_J     = 6'h02
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       illegal_op
);
   typedef enum logic [STATE_W-1:0] {
      S_RESET    = STATE_W'(0),
      S_FETCH    = STATE_W'(1),
      S_DECODE   = STATE_W'(2),
      S_MEMADR   = STATE_W'(3),
      S_MEMREAD  = STATE_W'(4),
      S_MEMWB    = STATE_W'(5),
      S_MEMWRITE = STATE_W'(6),
      S_EXECUTE  = STATE_W'(7),
      S_ALUWB    = STATE_W'(8),
      S_BRANCH   = STATE_W'(9),
      S_ADDIEX   = STATE_W'(10),
`ifdef MC_JUMP_EN
      S_ADDIWB   = STATE_W'(11),
      S_JUMP     = STATE_W'(12)
`else
      S_ADDIWB   = STATE_W'(11)
`endif
   } state_t;

   state_t     r_state, w_next, w_ns;
   logic       r_iord, r_memwrite, r_fetch, r_regdst, r_memtoreg, r_regwrite, r_alusrca;
   logic       r_pcwrite, r_branch, r_decode;
   logic [1:0] r_alusrcb, r_aluop, r_pcsrc;
   logic       w_iord, w_memwrite, w_fetch, w_regdst, w_memtoreg, w_regwrite, w_alusrca;
   logic       w_pcwrite, w_branch, w_decode;
   logic [1:0] w_alusrcb, w_aluop, w_pcsrc;
   logic       w_is_j, w_known, w_legal;

   assign w_is_j  = (opcode == OP_J);
   assign w_known = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
                    (opcode == OP_BEQ) || (opcode == OP_ADDI);
`ifdef MC_JUMP_EN
   assign w_legal = w_known | w_is_j;
`else
   assign w_legal = w_known & ~w_is_j;
`endif

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:   w_next = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                              (opcode == OP_RTYPE) ? S_EXECUTE :
                              (opcode == OP_BEQ)   ? S_BRANCH  :
                              (opcode == OP_ADDI)  ? S_ADDIEX  : S_FETCH;
         S_MEMADR:   w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:  w_next = S_ALUWB;
         S_ADDIEX:   w_next = S_ADDIWB;
         default:    w_next = S_FETCH;
      endcase
`ifdef MC_JUMP_EN
      if (r_state == S_DECODE && w_is_j) w_next = S_JUMP;
`endif
      w_ns = rst ? S_RESET : w_next;
   end

   // Outputs are decoded from the next state and registered, so they line up with r_state.
   always_comb begin
      w_iord     = 1'b0;
      w_memwrite = 1'b0;
      w_fetch    = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_regwrite = 1'b0;
      w_alusrca  = 1'b0;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_decode   = 1'b0;
      w_alusrcb  = 2'b00;
      w_aluop    = 2'b00;
      w_pcsrc    = 2'b00;
      case (w_ns)
         S_FETCH:    begin w_fetch = 1'b1; w_alusrcb = 2'b01; end
         S_DECODE:   begin w_decode = 1'b1; w_alusrcb = 2'b11; end
         S_MEMADR:   begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
         S_MEMREAD:  w_iord = 1'b1;
         S_MEMWB:    begin w_memtoreg = 1'b1; w_regwrite = 1'b1; end
         S_MEMWRITE: begin w_iord = 1'b1; w_memwrite = 1'b1; end
         S_EXECUTE:  begin w_alusrca = 1'b1; w_aluop = 2'b10; end
         S_ALUWB:    begin w_regdst = 1'b1; w_regwrite = 1'b1; end
         S_BRANCH:   begin w_alusrca = 1'b1; w_aluop = 2'b01; w_pcsrc = 2'b01; w_branch = 1'b1; end
         S_ADDIEX:   begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
         S_ADDIWB:   w_regwrite = 1'b1;
`ifdef MC_JUMP_EN
         S_JUMP:     begin w_pcsrc = 2'b10; w_pcwrite = 1'b1; end
`endif
         default:    w_iord = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      r_state    <= w_ns;
      r_iord     <= w_iord;
      r_memwrite <= w_memwrite;
      r_fetch    <= w_fetch;
      r_regdst   <= w_regdst;
      r_memtoreg <= w_memtoreg;
      r_regwrite <= w_regwrite;
      r_alusrca  <= w_alusrca;
      r_pcwrite  <= w_pcwrite;
      r_branch   <= w_branch;
      r_decode   <= w_decode;
      r_alusrcb  <= w_alusrcb;
      r_aluop    <= w_aluop;
      r_pcsrc    <= w_pcsrc;
   end

   assign IorD       = r_iord;
   assign MemWrite   = r_memwrite;
   assign IRWrite    = r_fetch & mem_ready;
   assign RegDst     = r_regdst;
   assign MemtoReg   = r_memtoreg;
   assign RegWrite   = r_regwrite;
   assign ALUSrcA    = r_alusrca;
   assign ALUSrcB    = r_alusrcb;
   assign ALUOp      = r_aluop;
   assign PCSrc      = r_pcsrc;
   assign PCEn       = (r_fetch & mem_ready) | r_pcwrite | (r_branch & zero);
   assign illegal_op = r_decode & ~w_legal;
endmodule

// File: tb/tb_mc_main_control_fsm.sv
// tb_mc_main_control_fsm: scoreboard bench for the multicycle control FSM.
// Each test queues per-cycle stimulus with its expected output word, then drains the queue.
module tb_mc_main_control_fsm;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'h00;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal_op;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;

   int n_chk  = 0;
   int n_fail = 0;

   // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn,illegal_op}
   localparam logic [14:0] E_ZERO   = 15'b0_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [14:0] E_FETCH  = 15'b0_0_1_0_0_0_0_01_00_00_1_0;
   localparam logic [14:0] E_FWAIT  = 15'b0_0_0_0_0_0_0_01_00_00_0_0;
   localparam logic [14:0] E_DECODE = 15'b0_0_0_0_0_0_0_11_00_00_0_0;
   localparam logic [14:0] E_ILLEG  = 15'b0_0_0_0_0_0_0_11_00_00_0_1;
   localparam logic [14:0] E_MEMADR = 15'b0_0_0_0_0_0_1_10_00_00_0_0;
   localparam logic [14:0] E_MEMRD  = 15'b1_0_0_0_0_0_0_00_00_00_0_0;
   localparam logic [14:0] E_MEMWB  = 15'b0_0_0_0_1_1_0_00_00_00_0_0;
   localparam logic [14:0] E_MEMWR  = 15'b1_1_0_0_0_0_0_00_00_00_0_0;
   localparam logic [14:0] E_EXEC   = 15'b0_0_0_0_0_0_1_00_10_00_0_0;
   localparam logic [14:0] E_ALUWB  = 15'b0_0_0_1_0_1_0_00_00_00_0_0;
   localparam logic [14:0] E_BRT    = 15'b0_0_0_0_0_0_1_00_01_01_1_0;
   localparam logic [14:0] E_BRNT   = 15'b0_0_0_0_0_0_1_00_01_01_0_0;
   localparam logic [14:0] E_ADDIWB = 15'b0_0_0_0_0_1_0_00_00_00_0_0;
   localparam logic [14:0] E_JUMP   = 15'b0_0_0_0_0_0_0_00_00_10_1_0;

   typedef struct {
      string       nm;
      logic [5:0]  op;
      logic        z;
      logic        mr;
      logic        rs;
      logic        chk;
      logic [14:0] exp;
   } step_t;

   step_t sq[$];

   mc_main_control_fsm dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   task automatic add(input string nm, input logic [5:0] op, input logic z, input logic mr,
                      input logic rs, input logic chk, input logic [14:0] exp);
      step_t s;
      s.nm = nm; s.op = op; s.z = z; s.mr = mr; s.rs = rs; s.chk = chk; s.exp = exp;
      sq.push_back(s);
   endtask

   // Drive one queued cycle at the falling edge and sample the outputs 1ns later.
   task automatic pop_step(output step_t s, output logic [14:0] obs);
      @(negedge clk);
      s = sq.pop_front();
      opcode = s.op; zero = s.z; mem_ready = s.mr; rst = s.rs;
      #1;
      obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
             PCSrc, PCEn, illegal_op};
   endtask

   task automatic test_reset();
      step_t s;
      logic [14:0] obs;
      add("rst_enter", 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, E_ZERO);
      add("rst_hold",  6'h00, 1'b0, 1'b1, 1'b1, 1'b1, E_ZERO);
      add("rst_state", 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_ZERO);
      add("rst_fetch_wait", 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, E_FWAIT);
      add("rst_fetch", 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("rst_decode_bad", 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, E_ILLEG);
      while (sq.size() > 0) begin
         pop_step(s, obs);
         if (s.chk) begin
            n_chk++;
            if (obs !== s.exp) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b", s.nm, obs, s.exp);
            end
         end
      end
   endtask

   task automatic test_lw();
      step_t s;
      logic [14:0] obs;
      add("lw_fetch",   6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("lw_decode",  6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("lw_memadr",  6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_MEMADR);
      add("lw_memread", 6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_MEMRD);
      add("lw_memwb",   6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_MEMWB);
      while (sq.size() > 0) begin
         pop_step(s, obs);
         if (s.chk) begin
            n_chk++;
            if (obs !== s.exp) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b", s.nm, obs, s.exp);
            end
         end
      end
   endtask

   task automatic test_sw_wait();
      step_t s;
      logic [14:0] obs;
      add("sw_fetch",  6'h2B, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("sw_decode", 6'h2B, 1'b0, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("sw_memadr", 6'h2B, 1'b0, 1'b1, 1'b0, 1'b1, E_MEMADR);
      for (int i = 0; i < 3; i++) add($sformatf("sw_wait%0d", i), 6'h2B, 1'b0, 1'b0, 1'b0, 1'b1, E_MEMWR);
      add("sw_accept", 6'h2B, 1'b0, 1'b1, 1'b0, 1'b1, E_MEMWR);
      add("sw_next_fetch", 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("sw_next_decode", 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("sw_next_exec", 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_EXEC);
      add("sw_next_aluwb", 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_ALUWB);
      while (sq.size() > 0) begin
         pop_step(s, obs);
         if (s.chk) begin
            n_chk++;
            if (obs !== s.exp) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b", s.nm, obs, s.exp);
            end
         end
      end
   endtask

   task automatic test_beq();
      step_t s;
      logic [14:0] obs;
      add("beq1_fetch",  6'h04, 1'b1, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("beq1_decode", 6'h04, 1'b1, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("beq1_taken",  6'h04, 1'b1, 1'b1, 1'b0, 1'b1, E_BRT);
      add("beq0_fetch",  6'h04, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("beq0_decode", 6'h04, 1'b0, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("beq0_not",    6'h04, 1'b0, 1'b1, 1'b0, 1'b1, E_BRNT);
      while (sq.size() > 0) begin
         pop_step(s, obs);
         if (s.chk) begin
            n_chk++;
            if (obs !== s.exp) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b", s.nm, obs, s.exp);
            end
         end
      end
   endtask

   task automatic test_rtype_addi();
      step_t s;
      logic [14:0] obs;
      add("r_fetch",     6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("r_decode",    6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("r_exec",      6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_EXEC);
      add("r_aluwb",     6'h00, 1'b0, 1'b1, 1'b0, 1'b1, E_ALUWB);
      add("addi_fetch",  6'h08, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("addi_decode", 6'h08, 1'b0, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("addi_ex",     6'h08, 1'b0, 1'b1, 1'b0, 1'b1, E_MEMADR);
      add("addi_wb",     6'h08, 1'b0, 1'b1, 1'b0, 1'b1, E_ADDIWB);
      while (sq.size() > 0) begin
         pop_step(s, obs);
         if (s.chk) begin
            n_chk++;
            if (obs !== s.exp) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b", s.nm, obs, s.exp);
            end
         end
      end
   endtask

   task automatic test_illegal_jump_reset();
      step_t s;
      logic [14:0] obs;
      add("ill_fetch",  6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("ill_decode", 6'h3F, 1'b0, 1'b1, 1'b0, 1'b1, E_ILLEG);
      add("j_fetch",    6'h02, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
`ifdef MC_JUMP_EN
      add("j_decode",   6'h02, 1'b0, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("j_jump",     6'h02, 1'b0, 1'b1, 1'b0, 1'b1, E_JUMP);
`else
      add("j_decode_ill", 6'h02, 1'b0, 1'b1, 1'b0, 1'b1, E_ILLEG);
`endif
      add("rr_fetch",   6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      add("rr_decode",  6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_DECODE);
      add("rr_memadr",  6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_MEMADR);
      add("rr_memread", 6'h23, 1'b0, 1'b0, 1'b1, 1'b1, E_MEMRD);
      add("rr_reset",   6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_ZERO);
      add("rr_fetch2",  6'h23, 1'b0, 1'b1, 1'b0, 1'b1, E_FETCH);
      while (sq.size() > 0) begin
         pop_step(s, obs);
         if (s.chk) begin
            n_chk++;
            if (obs !== s.exp) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b", s.nm, obs, s.exp);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_beq();
      test_rtype_addi();
      test_illegal_jump_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
